// File: rtl/pipe_fwd_scoreboard_pkg.sv
// Shared types and constants for the forwarding scoreboard.
//   slot_t      : one in-flight destination tag {valid, rd, is_load}
//   FWD_SEL_RF  : select code meaning "use the register-file value"
//   REG_ZERO    : the hard-wired zero register address
// Register addresses are carried at REG_AW_MAX bits internally so the
// slot type can live in a package; narrower REG_AW values are zero-extended.
package pipe_fwd_scoreboard_pkg;

  localparam int unsigned REG_AW_MAX = 8;

  localparam logic [2:0]            FWD_SEL_RF = 3'd0;
  localparam logic [REG_AW_MAX-1:0] REG_ZERO   = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rd;
    logic                  is_load;
  } slot_t;

endpackage

// File: rtl/pipe_fwd_scoreboard_if.sv
// Bundle of execute/decode-side signals for pipe_fwd_scoreboard.
//   master : pipeline side, drives control/operand inputs, reads results
//   slave  : scoreboard side
// Optional counters stat_fwd_cnt / stat_stall_cnt exist only when the
// FWD_STATS_EN macro is defined.
interface pipe_fwd_scoreboard_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_STAGES = 2
);
  logic                         advance;
  logic                         flush;
  logic                         ex_wen;
  logic [REG_AW-1:0]            ex_rd;
  logic                         ex_is_load;
  logic [REG_AW-1:0]            ex_rs_a;
  logic [REG_AW-1:0]            ex_rs_b;
  logic [DATA_W-1:0]            ex_a_rf;
  logic [DATA_W-1:0]            ex_b_rf;
  logic [FWD_STAGES*DATA_W-1:0] slot_data;
  logic [REG_AW-1:0]            dec_rs_a;
  logic [REG_AW-1:0]            dec_rs_b;
  logic [DATA_W-1:0]            op_a;
  logic [DATA_W-1:0]            op_b;
  logic [2:0]                   fwd_sel_a;
  logic [2:0]                   fwd_sel_b;
  logic                         load_use_stall;
`ifdef FWD_STATS_EN
  logic [31:0]                  stat_fwd_cnt;
  logic [31:0]                  stat_stall_cnt;
`endif

  modport master (
    output advance, flush, ex_wen, ex_rd, ex_is_load, ex_rs_a, ex_rs_b,
           ex_a_rf, ex_b_rf, slot_data, dec_rs_a, dec_rs_b,
    input  op_a, op_b, fwd_sel_a, fwd_sel_b, load_use_stall
`ifdef FWD_STATS_EN
    , input stat_fwd_cnt, stat_stall_cnt
`endif
  );

  modport slave (
    input  advance, flush, ex_wen, ex_rd, ex_is_load, ex_rs_a, ex_rs_b,
           ex_a_rf, ex_b_rf, slot_data, dec_rs_a, dec_rs_b,
    output op_a, op_b, fwd_sel_a, fwd_sel_b, load_use_stall
`ifdef FWD_STATS_EN
    , output stat_fwd_cnt, stat_stall_cnt
`endif
  );

endinterface

// File: rtl/pipe_fwd_scoreboard_fwd_select.sv
// Combinational priority match of one source register against the slot chain.
//   i_src       : source register (zero-extended)
//   i_rf        : register-file value used when nothing matches
//   i_chain     : slot tags, index k-1 holds slot k
//   i_slot_data : result data, slot k at [k*DATA_W-1 -: DATA_W]
//   o_sel       : 0 = regfile, k = slot k
//   o_data      : selected operand
module fwd_select
  import pipe_fwd_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LOAD_SLOT  = 2
) (
  input  logic [REG_AW_MAX-1:0]        i_src,
  input  logic [DATA_W-1:0]            i_rf,
  input  slot_t [FWD_STAGES-1:0]       i_chain,
  input  logic [FWD_STAGES*DATA_W-1:0] i_slot_data,
  output logic [2:0]                   o_sel,
  output logic [DATA_W-1:0]            o_data
);

  // Walk oldest to youngest so the youngest match is the last assignment.
  always_comb begin
    o_sel  = FWD_SEL_RF;
    o_data = i_rf;
    for (int unsigned k = FWD_STAGES; k >= 1; k--) begin
      if (i_chain[k-1].valid && (i_chain[k-1].rd == i_src) &&
          (i_src != REG_ZERO) &&
          (!i_chain[k-1].is_load || (k >= LOAD_SLOT))) begin
        o_sel  = 3'(k);
        o_data = i_slot_data[(k-1)*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/pipe_fwd_scoreboard.sv
// Parametrised bypass / load-use hazard unit. Keeps a shadow chain of
// in-flight destination tags (one slot per post-execute stage), selects
// forwarded execute operands and raises load_use_stall for decode.
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : pipe_fwd_scoreboard_if.slave (execute/decode signals, results)
// Optional feature macro: FWD_STATS_EN adds saturating forward/stall counters.
module pipe_fwd_scoreboard
  import pipe_fwd_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LOAD_SLOT  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  pipe_fwd_scoreboard_if.slave bus
);

  slot_t [FWD_STAGES-1:0] r_chain;

  logic [REG_AW_MAX-1:0] w_ex_rd;
  logic [REG_AW_MAX-1:0] w_ex_rs_a;
  logic [REG_AW_MAX-1:0] w_ex_rs_b;
  logic [REG_AW_MAX-1:0] w_dec_a;
  logic [REG_AW_MAX-1:0] w_dec_b;
  logic                  w_stall;
  logic [2:0]            w_sel_a;
  logic [2:0]            w_sel_b;

  assign w_ex_rd   = REG_AW_MAX'(bus.ex_rd);
  assign w_ex_rs_a = REG_AW_MAX'(bus.ex_rs_a);
  assign w_ex_rs_b = REG_AW_MAX'(bus.ex_rs_b);
  assign w_dec_a   = REG_AW_MAX'(bus.dec_rs_a);
  assign w_dec_b   = REG_AW_MAX'(bus.dec_rs_b);

  // A load is hazardous until it reaches LOAD_SLOT; the stall looks one
  // stage ahead because the dependent will be in execute next cycle.
  always_comb begin
    w_stall = 1'b0;
    if ((LOAD_SLOT > 1) && bus.ex_wen && bus.ex_is_load && !bus.flush &&
        (w_ex_rd != REG_ZERO) && ((w_ex_rd == w_dec_a) || (w_ex_rd == w_dec_b)))
      w_stall = 1'b1;
    for (int unsigned k = 1; k <= FWD_STAGES; k++) begin
      if ((k + 1 < LOAD_SLOT) && r_chain[k-1].valid && r_chain[k-1].is_load &&
          (r_chain[k-1].rd != REG_ZERO) &&
          ((r_chain[k-1].rd == w_dec_a) || (r_chain[k-1].rd == w_dec_b)))
        w_stall = 1'b1;
    end
  end

  assign bus.load_use_stall = w_stall;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_chain <= '0;
    end else if (bus.advance) begin
      r_chain[0].valid   <= bus.ex_wen && !bus.flush && !w_stall && (w_ex_rd != REG_ZERO);
      r_chain[0].rd      <= w_ex_rd;
      r_chain[0].is_load <= bus.ex_is_load;
      for (int unsigned k = 1; k < FWD_STAGES; k++)
        r_chain[k] <= r_chain[k-1];
    end
  end

  fwd_select #(.DATA_W(DATA_W), .FWD_STAGES(FWD_STAGES), .LOAD_SLOT(LOAD_SLOT)) u_sel_a (
    .i_src       (w_ex_rs_a),
    .i_rf        (bus.ex_a_rf),
    .i_chain     (r_chain),
    .i_slot_data (bus.slot_data),
    .o_sel       (w_sel_a),
    .o_data      (bus.op_a)
  );

  fwd_select #(.DATA_W(DATA_W), .FWD_STAGES(FWD_STAGES), .LOAD_SLOT(LOAD_SLOT)) u_sel_b (
    .i_src       (w_ex_rs_b),
    .i_rf        (bus.ex_b_rf),
    .i_chain     (r_chain),
    .i_slot_data (bus.slot_data),
    .o_sel       (w_sel_b),
    .o_data      (bus.op_b)
  );

  assign bus.fwd_sel_a = w_sel_a;
  assign bus.fwd_sel_b = w_sel_b;

`ifdef FWD_STATS_EN
  logic [31:0] r_fwd_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fwd_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (bus.advance && ((w_sel_a != FWD_SEL_RF) || (w_sel_b != FWD_SEL_RF)) &&
          (r_fwd_cnt != '1))
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.stat_fwd_cnt   = r_fwd_cnt;
  assign bus.stat_stall_cnt = r_stall_cnt;
`endif

endmodule
